// File: rtl/parking_occupancy.sv
// Lot occupancy tracker: turns enter/exit pulses into binary and BCD occupancy,
// full/empty status, sticky over/underflow flags, entry total and peak record.
module parking_occupancy #(
    parameter int unsigned CAPACITY = 25,
    parameter int unsigned CW       = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enter,
    input  logic          exit,
    input  logic          clr_err,
    output logic [CW-1:0] count,
    output logic [3:0]    count_tens,
    output logic [3:0]    count_ones,
    output logic          full,
    output logic          empty,
    output logic          err_over,
    output logic          err_under,
    output logic [7:0]    total_entries,
    output logic [CW-1:0] peak
);

    localparam logic [CW-1:0] CAP = CW'(CAPACITY);

    logic          inc;
    logic          dec;
    logic          set_over;
    logic          set_under;
    logic          accept;
    logic [CW-1:0] count_next;
    logic [3:0]    tens_next;
    logic [3:0]    ones_next;

    assign full  = (count == CAP);
    assign empty = (count == '0);

    // Event decode against the pre-edge count; simultaneous pulses cancel
    always_comb begin
        inc       = enter & ~exit & ~full;
        dec       = exit & ~enter & ~empty;
        set_over  = enter & ~exit & full;
        set_under = exit & ~enter & empty;
        accept    = enter & (exit | ~full);
    end

    // Binary and BCD next values move in lockstep
    always_comb begin
        count_next = count;
        tens_next  = count_tens;
        ones_next  = count_ones;
        if (inc) begin
            count_next = count + CW'(1);
            if (count_ones == 4'd9) begin
                ones_next = 4'd0;
                tens_next = count_tens + 4'd1;
            end else begin
                ones_next = count_ones + 4'd1;
            end
        end else if (dec) begin
            count_next = count - CW'(1);
            if (count_ones == 4'd0) begin
                ones_next = 4'd9;
                tens_next = count_tens - 4'd1;
            end else begin
                ones_next = count_ones - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count         <= '0;
            count_tens    <= 4'd0;
            count_ones    <= 4'd0;
            total_entries <= 8'd0;
            peak          <= '0;
            err_over      <= 1'b0;
            err_under     <= 1'b0;
        end else begin
            count      <= count_next;
            count_tens <= tens_next;
            count_ones <= ones_next;
            if (accept) begin
                total_entries <= total_entries + 8'd1;
            end
            if (count_next > peak) begin
                peak <= count_next;
            end
            // A new error event in the same cycle as clr_err keeps the flag set
            err_over  <= set_over  | (err_over  & ~clr_err);
            err_under <= set_under | (err_under & ~clr_err);
        end
    end

endmodule

// File: tb/tb_parking_occupancy.sv
// Bench for parking_occupancy: arithmetic reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_parking_occupancy;

    localparam int unsigned CAPACITY = 25;
    localparam int unsigned CW       = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enter = 1'b0;
    logic          exit = 1'b0;
    logic          clr_err = 1'b0;
    logic [CW-1:0] count;
    logic [3:0]    count_tens;
    logic [3:0]    count_ones;
    logic          full;
    logic          empty;
    logic          err_over;
    logic          err_under;
    logic [7:0]    total_entries;
    logic [CW-1:0] peak;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    int m_count = 0;
    int m_total = 0;
    int m_peak = 0;
    bit m_over = 1'b0;
    bit m_under = 1'b0;

    parking_occupancy #(.CAPACITY(CAPACITY), .CW(CW)) dut (
        .clk(clk),
        .reset(reset),
        .enter(enter),
        .exit(exit),
        .clr_err(clr_err),
        .count(count),
        .count_tens(count_tens),
        .count_ones(count_ones),
        .full(full),
        .empty(empty),
        .err_over(err_over),
        .err_under(err_under),
        .total_entries(total_entries),
        .peak(peak)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: occupancy rules stated directly in integer arithmetic
    always @(posedge clk) begin
        int c, t, p;
        bit o, u;
        c = m_count; t = m_total; p = m_peak; o = m_over; u = m_under;
        if (reset) begin
            c = 0; t = 0; p = 0; o = 0; u = 0;
        end else begin
            if (clr_err) begin o = 0; u = 0; end
            if (enter && !exit) begin
                if (c < CAPACITY) begin c = c + 1; t = (t + 1) % 256; end
                else o = 1;
            end else if (exit && !enter) begin
                if (c > 0) c = c - 1;
                else u = 1;
            end else if (enter && exit) begin
                t = (t + 1) % 256;
            end
            if (c > p) p = c;
        end
        m_count <= c; m_total <= t; m_peak <= p; m_over <= o; m_under <= u;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("count", int'(count), m_count);
            check("tens", int'(count_tens), m_count / 10);
            check("ones", int'(count_ones), m_count % 10);
            check("full", int'(full), int'(m_count == CAPACITY));
            check("empty", int'(empty), int'(m_count == 0));
            check("err_over", int'(err_over), int'(m_over));
            check("err_under", int'(err_under), int'(m_under));
            check("total_entries", int'(total_entries), m_total);
            check("peak", int'(peak), m_peak);
        end
    end

    // One clock: inputs applied now, captured by the next posedge
    task automatic cyc(input bit e, input bit x, input bit c);
        enter = e; exit = x; clr_err = c;
        @(negedge clk);
        enter = 1'b0; exit = 1'b0; clr_err = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic enters(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        chk_en = 1'b1;
        check("lit reset count", int'(count), 0);
        check("lit reset empty", int'(empty), 1);
        check("lit reset full", int'(full), 0);

        // Three spaced enters, each visible right after its edge
        for (int i = 1; i <= 3; i++) begin
            cyc(1, 0, 0);
            check("lit spaced count", int'(count), i);
            cyc(0, 0, 0);
        end
        check("lit 3 ones", int'(count_ones), 3);
        check("lit 3 total", int'(total_entries), 3);
        check("lit 3 peak", int'(peak), 3);
        check("lit 3 empty", int'(empty), 0);

        // BCD carry and borrow
        do_reset();
        enters(10);
        check("lit 10 tens", int'(count_tens), 1);
        check("lit 10 ones", int'(count_ones), 0);
        cyc(0, 1, 0);
        check("lit 9 count", int'(count), 9);
        check("lit 9 ones", int'(count_ones), 9);
        check("lit 9 tens", int'(count_tens), 0);
        check("lit 9 peak", int'(peak), 10);

        // Fill then overflow, then clear
        do_reset();
        enters(26);
        check("lit full count", int'(count), 25);
        check("lit full flag", int'(full), 1);
        check("lit err_over", int'(err_over), 1);
        check("lit full total", int'(total_entries), 25);
        cyc(0, 0, 1);
        check("lit over cleared", int'(err_over), 0);
        check("lit count after clr", int'(count), 25);

        // Underflow; set wins over simultaneous clear
        do_reset();
        cyc(0, 1, 0);
        check("lit under count", int'(count), 0);
        check("lit err_under", int'(err_under), 1);
        cyc(0, 1, 1);
        check("lit under set wins", int'(err_under), 1);
        cyc(0, 0, 1);
        check("lit under cleared", int'(err_under), 0);

        // Simultaneous pulses at empty, mid and full
        do_reset();
        cyc(1, 1, 0);
        check("lit both@0 count", int'(count), 0);
        check("lit both@0 under", int'(err_under), 0);
        enters(12);
        cyc(1, 1, 0);
        check("lit both@12 count", int'(count), 12);
        enters(13);
        cyc(1, 1, 0);
        check("lit both@25 count", int'(count), 25);
        check("lit both@25 over", int'(err_over), 0);
        check("lit both total", int'(total_entries), 28);

        // total_entries wrap at count 5, then reset mid-burst
        do_reset();
        enters(5);
        for (int i = 0; i < 256; i++) cyc(1, 1, 0);
        check("lit wrap total", int'(total_entries), 5);
        check("lit wrap count", int'(count), 5);
        for (int i = 0; i < 7; i++) cyc(1, 1, 0);
        enters(3);
        reset = 1'b1;
        cyc(1, 0, 0);
        reset = 1'b0;
        check("lit mid reset count", int'(count), 0);
        check("lit mid reset total", int'(total_entries), 0);
        check("lit mid reset peak", int'(peak), 0);
        check("lit mid reset empty", int'(empty), 1);
        cyc(0, 0, 0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
